tls_intersection: RTL and testbench

Parametrised two-approach (main/side) traffic-light controller, the successor to the single-signal TLS controller.
- Sequences main and side signal heads through green, yellow and all-red clearance phases with run-time programmable durations.
- Adds a latched pedestrian request with walk indication and a night flash mode.
- Keeps Set/Stop/Jump control semantics and sits directly behind the roadside I/O register block.

---
 rtl/tls_pkg.sv | 51 +++++
 rtl/tls_phase_timer.sv | 35 +++
 rtl/tls_intersection.sv | 148 ++++++++++++++
 tb/tb_tls_intersection.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tls_pkg.sv
// Shared phase codes, lamp vector and decode helpers for the intersection controller.
package tls_pkg;

  typedef enum logic [2:0] {
    PhMainG = 3'd0,
    PhMainY = 3'd1,
    PhAllrS = 3'd2,
    PhSideG = 3'd3,
    PhSideY = 3'd4,
    PhAllrM = 3'd5,
    PhFlash = 3'd6
  } phase_e;

  // Bit order MSB..LSB: main_g, main_y, main_r, side_g, side_y, side_r.
  typedef struct packed {
    logic main_g;
    logic main_y;
    logic main_r;
    logic side_g;
    logic side_y;
    logic side_r;
  } lamps_t;

  function automatic lamps_t lamp_decode(input phase_e ph, input logic blink);
    lamps_t l;
    l = '0;
    case (ph)
      PhMainG: begin l.main_g = 1'b1; l.side_r = 1'b1; end
      PhMainY: begin l.main_y = 1'b1; l.side_r = 1'b1; end
      PhAllrS,
      PhAllrM: begin l.main_r = 1'b1; l.side_r = 1'b1; end
      PhSideG: begin l.side_g = 1'b1; l.main_r = 1'b1; end
      PhSideY: begin l.side_y = 1'b1; l.main_r = 1'b1; end
      PhFlash: begin l.main_y = blink; l.side_r = blink; end
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PhMainG: return PhMainY;
      PhMainY: return PhAllrS;
      PhAllrS: return PhSideG;
      PhSideG: return PhSideY;
      PhSideY: return PhAllrM;
      default: return PhMainG;
    endcase
  endfunction

endpackage

// File: rtl/tls_phase_timer.sv
// Phase counter: counts 0..dur-1, flags the last cycle and reports cycles remaining.
module tls_phase_timer #(
  parameter int unsigned DUR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic [DUR_W-1:0] dur,
  output logic [DUR_W-1:0] count,
  output logic             done,
  output logic [DUR_W-1:0] remain
);

  logic [DUR_W-1:0] count_q;

  // dur is always >= 1 here, so dur-1-count never wraps.
  assign done   = (count_q == dur - DUR_W'(1));
  assign remain = dur - DUR_W'(1) - count_q;
  assign count  = count_q;

  // Counter: clear beats hold, wraps to zero after the last cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (hold) begin
      count_q <= count_q;
    end else if (done) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + DUR_W'(1);
    end
  end

endmodule

// File: rtl/tls_intersection.sv
// Two-approach traffic-light controller with pedestrian walk and night flash.
module tls_intersection
  import tls_pkg::*;
#(
  parameter int unsigned DUR_W      = 4,
  parameter int unsigned FLASH_HALF = 2,
  parameter int unsigned PED_EN     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             stop,
  input  logic             jump,
  input  logic             flash,
  input  logic             ped_req,
  input  logic [DUR_W-1:0] g_dur,
  input  logic [DUR_W-1:0] y_dur,
  input  logic [DUR_W-1:0] r_dur,
  output logic             main_g,
  output logic             main_y,
  output logic             main_r,
  output logic             side_g,
  output logic             side_y,
  output logic             side_r,
  output logic             walk,
  output logic [2:0]       phase,
  output logic [DUR_W-1:0] remain
);

  localparam int unsigned BcntW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  phase_e           phase_q;
  logic [DUR_W-1:0] g_q, y_q, r_q;
  logic             ped_q, walk_q, blink_q;
  logic [BcntW-1:0] bcnt_q;

  logic [DUR_W-1:0] eff_g, eff_y, eff_r, cur_dur, tmr_count;
  logic             tmr_done, tmr_clear, ped_early, adv, flash_exit, ped_in;
  phase_e           nxt;
  lamps_t           lamps;

  // A stored duration of zero still yields a one-cycle phase.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  assign eff_g = eff_dur(g_q);
  assign eff_y = eff_dur(y_q);
  assign eff_r = eff_dur(r_q);

  // Duration of the phase currently held in phase_q.
  always_comb begin
    cur_dur = DUR_W'(1);
    case (phase_q)
      PhMainG, PhSideG: cur_dur = eff_g;
      PhMainY, PhSideY: cur_dur = eff_y;
      PhAllrS, PhAllrM: cur_dur = eff_r;
      default:          cur_dur = DUR_W'(1);
    endcase
  end

  assign ped_in     = (PED_EN != 0) && ped_req && (phase_q != PhSideG);
  assign ped_early  = (PED_EN != 0) && (phase_q == PhMainG) && ped_q &&
                      (tmr_count >= (eff_g >> 1));
  assign adv        = tmr_done || ped_early;
  assign flash_exit = (phase_q == PhFlash) && !flash;
  assign nxt        = next_phase(phase_q);
  // Every forced phase change restarts the counter; an early ped exit must too.
  assign tmr_clear  = set || flash || flash_exit || jump || (!stop && ped_early);

  tls_phase_timer #(
    .DUR_W(DUR_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .hold   (stop),
    .dur    (cur_dur),
    .count  (tmr_count),
    .done   (tmr_done),
    .remain (remain)
  );

  // Phase FSM with duration registers, ped latch, walk and blink state.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PhMainG;
      g_q     <= DUR_W'(1);
      y_q     <= DUR_W'(1);
      r_q     <= DUR_W'(1);
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (set) begin
      phase_q <= PhMainG;
      g_q     <= g_dur;
      y_q     <= y_dur;
      r_q     <= r_dur;
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (flash) begin
      phase_q <= PhFlash;
      walk_q  <= 1'b0;
      if (ped_in) ped_q <= 1'b1;
      if (phase_q != PhFlash) begin
        blink_q <= 1'b1;
        bcnt_q  <= '0;
      end else if (bcnt_q == BcntW'(FLASH_HALF - 1)) begin
        blink_q <= ~blink_q;
        bcnt_q  <= '0;
      end else begin
        bcnt_q  <= bcnt_q + BcntW'(1);
      end
    end else begin
      if (ped_in) ped_q <= 1'b1;
      if (flash_exit) begin
        phase_q <= PhAllrM;
        walk_q  <= 1'b0;
      end else if (jump) begin
        phase_q <= PhAllrS;
        walk_q  <= 1'b0;
      end else if (!stop && adv) begin
        phase_q <= nxt;
        walk_q  <= 1'b0;
        if (nxt == PhSideG) begin
          // Consume the request on entry; it covers the whole side green.
          walk_q <= (PED_EN != 0) && (ped_q || ped_in);
          ped_q  <= 1'b0;
        end
      end
    end
  end

  // Lamps decode straight from the registered phase.
  assign lamps  = lamp_decode(phase_q, blink_q);
  assign main_g = lamps.main_g;
  assign main_y = lamps.main_y;
  assign main_r = lamps.main_r;
  assign side_g = lamps.side_g;
  assign side_y = lamps.side_y;
  assign side_r = lamps.side_r;
  assign walk   = walk_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_tls_intersection.sv
// Directed bench for tls_intersection with hand-computed phase/lamp/remain expectations.
module tb_tls_intersection;

  localparam int unsigned DUR_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, set, stop, jump, flash, ped_req;
  logic [DUR_W-1:0] g_dur, y_dur, r_dur;
  logic main_g, main_y, main_r, side_g, side_y, side_r, walk;
  logic [2:0] phase;
  logic [DUR_W-1:0] remain;

  int checks = 0;
  int errors = 0;

  tls_intersection #(
    .DUR_W      (DUR_W),
    .FLASH_HALF (2),
    .PED_EN     (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set     (set),
    .stop    (stop),
    .jump    (jump),
    .flash   (flash),
    .ped_req (ped_req),
    .g_dur   (g_dur),
    .y_dur   (y_dur),
    .r_dur   (r_dur),
    .main_g  (main_g),
    .main_y  (main_y),
    .main_r  (main_r),
    .side_g  (side_g),
    .side_y  (side_y),
    .side_r  (side_r),
    .walk    (walk),
    .phase   (phase),
    .remain  (remain)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {main_g, main_y, main_r, side_g, side_y, side_r} for a non-flash phase code.
  function automatic logic [5:0] lamps_for(input int ph);
    case (ph)
      0:       return 6'b100001;
      1:       return 6'b010001;
      2, 5:    return 6'b001001;
      3:       return 6'b001100;
      4:       return 6'b001010;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] lamps_now();
    return {main_g, main_y, main_r, side_g, side_y, side_r};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_set(input int g, input int y, input int r);
    set   = 1'b1;
    g_dur = DUR_W'(g);
    y_dur = DUR_W'(y);
    r_dur = DUR_W'(r);
    tick();
    set   = 1'b0;
  endtask

  task automatic check_state(input string tag, input int ph, input int rem);
    check({tag, "_phase"}, 32'(phase), 32'(ph));
    check({tag, "_lamps"}, 32'(lamps_now()), 32'(lamps_for(ph)));
    check({tag, "_remain"}, 32'(remain), 32'(rem));
  endtask

  initial begin
    int exp_ph[13]  = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
    int exp_rem[13] = '{2, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 2};
    logic b;

    reset = 1'b1; set = 1'b0; stop = 1'b0; jump = 1'b0; flash = 1'b0; ped_req = 1'b0;
    g_dur = '0; y_dur = '0; r_dur = '0;
    tick();
    check_state("reset", 0, 0);
    check("reset_walk", 32'(walk), 32'd0);
    reset = 1'b0;

    // Full normal cycle, g=3 y=2 r=1.
    do_set(3, 2, 1);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) tick();
      check_state($sformatf("cycle%0d", i), exp_ph[i], exp_rem[i]);
    end

    // Stop in SIDE_G at count=1.
    run(7);
    check_state("stop_pre", 3, 1);
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state($sformatf("stop_hold%0d", i), 3, 1);
    end
    stop = 1'b0;
    tick();
    check_state("stop_rel0", 3, 0);
    tick();
    check_state("stop_rel1", 4, 1);

    // Jump beats stop in MAIN_Y.
    do_set(3, 2, 3);
    run(3);
    check_state("jump_pre", 1, 1);
    jump = 1'b1; stop = 1'b1;
    tick();
    check_state("jump", 2, 2);
    jump = 1'b0; stop = 1'b0;
    tick();
    check_state("jump_after", 2, 1);

    // Pedestrian request shortens MAIN_G and gives walk for all of SIDE_G.
    do_set(8, 2, 1);
    tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check_state("ped_mg2", 0, 5);
    run(2);
    check_state("ped_mg4", 0, 3);
    tick();
    check_state("ped_early_my", 1, 1);
    run(3);
    for (int i = 0; i < 8; i++) begin
      check_state($sformatf("walk_sg%0d", i), 3, 7 - i);
      check($sformatf("walk_on%0d", i), 32'(walk), 32'd1);
      ped_req = (i == 2);
      tick();
    end
    check_state("walk_sy", 4, 1);
    check("walk_off", 32'(walk), 32'd0);
    run(8);
    check_state("ped_ignored_mg5", 0, 2);

    // Night flash.
    flash = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      b = ((i / 2) % 2 == 0);
      check($sformatf("flash_phase%0d", i), 32'(phase), 32'd6);
      check($sformatf("flash_lamps%0d", i), 32'(lamps_now()), 32'({1'b0, b, 3'b000, b}));
      check($sformatf("flash_remain%0d", i), 32'(remain), 32'd0);
    end
    flash = 1'b0;
    tick();
    check_state("flash_exit", 5, 0);
    tick();
    check_state("flash_back_mg", 0, 7);

    // Zero green duration, then reset mid-SIDE_Y.
    do_set(0, 2, 1);
    check_state("g0_mg", 0, 0);
    tick();
    check_state("g0_my", 1, 1);
    run(4);
    check_state("pre_reset_sy", 4, 1);
    reset = 1'b1; jump = 1'b1; flash = 1'b1; ped_req = 1'b1;
    tick();
    check_state("midreset", 0, 0);
    check("midreset_walk", 32'(walk), 32'd0);
    reset = 1'b0; jump = 1'b0; flash = 1'b0; ped_req = 1'b0;
    tick();
    check_state("dur1_my", 1, 0);
    tick();
    check_state("dur1_as", 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
